gardner_ted_v2: RTL
===================

Name: gardner_ted_v2

Overview:
- Parametrised, synthesizable Gardner timing-error detector for the MSK timing-recovery loop. Sits between the matched-filter I/Q stream and the PI loop filter.
- Holds the last OSF samples in a ring buffer and forms the Gardner error on each symbol strobe. Supports selectable error modes, optional averaging over 2^AVG_LOG2 symbols, and saturation to WERR bits.
- Provides a raw I/Q tap delayed by a parametrised number of samples, used to align the interpolator.

Parameters:
- OSF, 20, samples per symbol; must be even and >= 4.
- WIQ, 16, signed I/Q input width.
- WERR, 18, signed error output width.
- SHIFT, 16, arithmetic right shift applied to the raw error sum before saturation.
- AVG_LOG2, 0, log2 of the number of symbol errors summed per output; 0 means every strobe produces an output.
- RAW_DLY, 11, raw tap delay in iq_val samples; range 1..OSF.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- i_in  in  WIQ  signed I sample.
- q_in  in  WIQ  signed Q sample.
- iq_val  in  1  sample-valid qualifier.
- sym_valid_i  in  1  symbol strobe; honoured only in a cycle where iq_val is also high.
- mode_i  in  2  error mode: 0 = I+Q, 1 = I-only, 2 = sign-data, 3 = treated as 0.
- e_out_o  out  WERR  signed, saturated timing error.
- e_valid_o  out  1  one-cycle pulse marking a new e_out_o.
- i_raw_delay_o  out  WIQ  I sample delayed by RAW_DLY samples.
- q_raw_delay_o  out  WIQ  Q sample delayed by RAW_DLY samples.
- sat_cnt_o  out  16  output saturation event count (see Optional Feature).

Behaviour:
- Reset (reset_n low at a clk edge) clears:
  - ring buffer and write pointer;
  - fill counter and full flag;
  - accumulator, window count and stored mode;
  - e_out_o = 0, e_valid_o = 0, sat_cnt_o = 0.
- Ring buffer:
  - depth OSF; written only when iq_val is high; write pointer wraps from OSF-1 to 0.
  - x[n-k] is the sample written k iq_val cycles ago.
- Taps:
  - Ic = current i_in/q_in input (combinational).
  - Ih = x[n-OSF/2].
  - Ip = x[n-OSF].
- Full flag: set once OSF samples have been written since reset; stays set until the next reset. Strobes arriving before full are ignored: no accumulation, no output.
- Error terms:
  - dI = Ic - Ip, dQ = Qc - Qp, each WIQ+1 bits.
  - Mode 0: s = Ih*dI + Qh*dQ.
  - Mode 1: s = Ih*dI.
  - Mode 2: s = sgn(Ih)*dI*2^(WIQ-1) + sgn(Qh)*dQ*2^(WIQ-1), with sgn(0) = +1.
  - s width is 2*WIQ+2 bits, full precision.
- Accumulation: on each qualifying strobe, s is added to an accumulator of width 2*WIQ+2+AVG_LOG2 and the window count is incremented.
- Output:
  - When the count reaches 2^AVG_LOG2, out = acc_total >>> (SHIFT+AVG_LOG2), where acc_total is the sum including the current strobe's s.
  - out saturates to [-2^(WERR-1), 2^(WERR-1)-1].
  - e_out_o is registered and e_valid_o pulses high one clk after that strobe; the accumulator and count then clear in the same cycle.
  - e_out_o holds its value between pulses.
- Mode change: if mode_i on a qualifying strobe differs from the stored mode, the accumulator and count restart with that strobe as the window's first member, and the stored mode updates. No output is produced unless AVG_LOG2 = 0.
- Strobe without iq_val: ignored entirely.
- Raw taps: i/q_raw_delay_o = x[n-RAW_DLY], combinational read of the buffer; 0 until written after reset.
- Reset mid-window discards any partial accumulation.

Optional Feature:
- Macro GARDNER_TED_SAT_CNT_EN.
- Defined: sat_cnt_o increments by 1 each time an output saturates, and holds at 65535 (no wrap).
- Undefined: the counter logic is omitted and sat_cnt_o is tied to 0.

Test Plan:
- Fill check (OSF=20): iq_val continuous from reset, strobe at sample 15 -> no e_valid_o. Strobe at sample 25 -> e_valid_o pulses one cycle later.
- Constant I/Q = 1000, mode 0 -> every output e_out_o = 0.
- Ramp i_in = 100*n, q_in = 0, mode 1, strobe at n = 30, SHIFT = 16 -> Ih = 2000, dI = 2000, s = 4,000,000, e_out_o = 61.
- AVG_LOG2 = 2, same ramp, strobes at n = 30, 50, 70, 90 -> a single e_valid_o after the 4th strobe with e_out_o = 61; no pulses after the first three.
- Saturation: SHIFT = 8, Ih = Qh = 32767, Ic = Qc = 32767, Ip = Qp = -32768, mode 0 -> e_out_o = 131071. With GARDNER_TED_SAT_CNT_EN defined, sat_cnt_o = 1.
- Mode switch mid-window (AVG_LOG2 = 1): strobe in mode 0, then strobe in mode 1 -> no output; the next mode-1 strobe produces an output containing only the two mode-1 errors. Separately, a reset mid-window -> e_out_o = 0 and the fill restarts.

Source files
------------

// File: rtl/gardner_ted_v2.sv
// Gardner timing-error detector for the MSK timing-recovery loop: OSF-deep I/Q ring buffer,
// selectable error modes, optional 2^AVG_LOG2 averaging, saturation. Option: GARDNER_TED_SAT_CNT_EN.
module gardner_ted_v2 #(
    parameter int OSF      = 20,
    parameter int WIQ      = 16,
    parameter int WERR     = 18,
    parameter int SHIFT    = 16,
    parameter int AVG_LOG2 = 0,
    parameter int RAW_DLY  = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic signed [WIQ-1:0]  i_in,
    input  logic signed [WIQ-1:0]  q_in,
    input  logic                   iq_val,
    input  logic                   sym_valid_i,
    input  logic [1:0]             mode_i,
    output logic signed [WERR-1:0] e_out_o,
    output logic                   e_valid_o,
    output logic signed [WIQ-1:0]  i_raw_delay_o,
    output logic signed [WIQ-1:0]  q_raw_delay_o,
    output logic [15:0]            sat_cnt_o
);

    localparam int WS = 2*WIQ + 2;
    localparam int WA = WS + AVG_LOG2;
    localparam int WX = (WA > WERR) ? WA : WERR;
    localparam int WP = $clog2(OSF);
    localparam int WF = $clog2(OSF + 1);
    localparam int WC = AVG_LOG2 + 1;
    localparam logic signed [WX-1:0] SAT_MAX = {{(WX-WERR+1){1'b0}}, {(WERR-1){1'b1}}};
    localparam logic signed [WX-1:0] SAT_MIN = {{(WX-WERR+1){1'b1}}, {(WERR-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_IQ  = 2'd0,
        MODE_I   = 2'd1,
        MODE_SGN = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    logic signed [WIQ-1:0] r_buf_i [OSF];
    logic signed [WIQ-1:0] r_buf_q [OSF];
    logic [WP-1:0]         r_wptr;
    logic [WF-1:0]         r_fill;
    logic                  r_full;
    logic signed [WA-1:0]  r_acc;
    logic [WC-1:0]         r_cnt;
    mode_e                 r_mode;
    logic signed [WERR-1:0] r_eout;
    logic                  r_valid;

    // Offset k samples forward from the write pointer, i.e. the sample written OSF-k writes ago.
    function automatic logic [WP-1:0] idx_add(input logic [WP-1:0] p, input int k);
        int t;
        t = int'(p) + k;
        if (t >= OSF) t -= OSF;
        return t[WP-1:0];
    endfunction

    logic [WP-1:0]         w_ih_idx, w_raw_idx;
    logic signed [WIQ-1:0] w_ih, w_qh, w_ip, w_qp;
    logic signed [WIQ:0]   w_di, w_dq;
    logic signed [WS-1:0]  w_pi, w_pq, w_si, w_sq, w_s;
    mode_e                 w_mode;
    logic                  w_strobe, w_restart, w_done, w_sat_hi, w_sat_lo;
    logic signed [WA-1:0]  w_acc_base, w_acc_total;
    logic [WC-1:0]         w_cnt_next;
    logic signed [WX-1:0]  w_ext;
    logic signed [WERR-1:0] w_out;

    assign w_ih_idx  = idx_add(r_wptr, OSF/2);
    assign w_raw_idx = idx_add(r_wptr, OSF - RAW_DLY);
    assign w_ih      = r_buf_i[w_ih_idx];
    assign w_qh      = r_buf_q[w_ih_idx];
    assign w_ip      = r_buf_i[r_wptr];
    assign w_qp      = r_buf_q[r_wptr];

    assign i_raw_delay_o = r_buf_i[w_raw_idx];
    assign q_raw_delay_o = r_buf_q[w_raw_idx];

    assign w_di = (WIQ+1)'(i_in) - (WIQ+1)'(w_ip);
    assign w_dq = (WIQ+1)'(q_in) - (WIQ+1)'(w_qp);
    assign w_pi = WS'(w_ih) * WS'(w_di);
    assign w_pq = WS'(w_qh) * WS'(w_dq);
    assign w_si = (w_ih[WIQ-1] ? -WS'(w_di) : WS'(w_di)) <<< (WIQ-1);
    assign w_sq = (w_qh[WIQ-1] ? -WS'(w_dq) : WS'(w_dq)) <<< (WIQ-1);

    assign w_mode = (mode_e'(mode_i) == MODE_RSV) ? MODE_IQ : mode_e'(mode_i);

    // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_s = w_pi + w_pq;
        case (w_mode)
            MODE_I:   w_s = w_pi;
            MODE_SGN: w_s = w_si + w_sq;
            default:  w_s = w_pi + w_pq;
        endcase
    end

    assign w_strobe    = iq_val & sym_valid_i & r_full;
    assign w_restart   = (w_mode != r_mode);
    assign w_acc_base  = w_restart ? '0 : r_acc;
    assign w_acc_total = w_acc_base + WA'(w_s);
    assign w_cnt_next  = (w_restart ? '0 : r_cnt) + WC'(1);
    assign w_done      = (w_cnt_next == WC'(2**AVG_LOG2));

    assign w_ext    = WX'(w_acc_total >>> (SHIFT + AVG_LOG2));
    assign w_sat_hi = (w_ext > SAT_MAX);
    assign w_sat_lo = (w_ext < SAT_MIN);
    assign w_out    = w_sat_hi ? SAT_MAX[WERR-1:0] :
                      w_sat_lo ? SAT_MIN[WERR-1:0] : w_ext[WERR-1:0];

    // NOTE: the sample buffer is reset too, so early taps and the raw delay read as zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < OSF; k++) begin
                r_buf_i[k] <= '0;
                r_buf_q[k] <= '0;
            end
            r_wptr <= '0;
            r_fill <= '0;
            r_full <= 1'b0;
        end else if (iq_val) begin
            r_buf_i[r_wptr] <= i_in;
            r_buf_q[r_wptr] <= q_in;
            r_wptr <= (r_wptr == WP'(OSF-1)) ? '0 : r_wptr + WP'(1);
            if (!r_full) begin
                r_fill <= r_fill + WF'(1);
                if (r_fill == WF'(OSF-1)) r_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_IQ;
            r_eout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_strobe) begin
                r_mode <= w_mode;
                if (w_done) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_eout  <= w_out;
                    r_valid <= 1'b1;
                end else begin
                    r_acc <= w_acc_total;
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign e_out_o   = r_eout;
    assign e_valid_o = r_valid;

`ifdef GARDNER_TED_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sat_cnt <= '0;
        end else if (w_strobe && w_done && (w_sat_hi || w_sat_lo) && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt_o = r_sat_cnt;
`else
    assign sat_cnt_o = '0;
`endif

endmodule
